// File: rtl/vga_scan_out_if.sv
// Signal bundle between the VGA scan-out block, the compositor, the pixel ROM
// and the VGA pins. The scan-out block is the master side.
interface vga_scan_out_if;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic [16:0] pixel_addr;
    logic        notBlank;
    logic        dim;
    logic [16:0] rom_addr;
    logic [11:0] rom_data;
    logic [3:0]  vgaRed;
    logic [3:0]  vgaGreen;
    logic [3:0]  vgaBlue;
    logic        hsync;
    logic        vsync;
    logic        frame_start;

    modport master (
        output h_cnt, v_cnt, rom_addr,
        output vgaRed, vgaGreen, vgaBlue, hsync, vsync, frame_start,
        input  pixel_addr, notBlank, dim, rom_data
    );

    modport slave (
        input  h_cnt, v_cnt, rom_addr,
        input  vgaRed, vgaGreen, vgaBlue, hsync, vsync, frame_start,
        output pixel_addr, notBlank, dim, rom_data
    );
endinterface

// File: rtl/vga_scan_out.sv
// VGA 640x480@60 scan-out: pixel-rate divider, scan counters, and a two-tick
// pipeline (ROM address / flags, then colour and syncs) so colour and syncs
// reach the pins with the same latency. Timing parameters default to the
// standard 800x525 raster; smaller rasters are only for fast simulation.
module vga_scan_out #(
    parameter logic [9:0] H_VISIBLE    = 10'd640,
    parameter logic [9:0] H_SYNC_START = 10'd656,
    parameter logic [9:0] H_SYNC_END   = 10'd751,
    parameter logic [9:0] H_MAX        = 10'd799,
    parameter logic [9:0] V_VISIBLE    = 10'd480,
    parameter logic [9:0] V_SYNC_START = 10'd490,
    parameter logic [9:0] V_SYNC_END   = 10'd491,
    parameter logic [9:0] V_MAX        = 10'd524
) (
    input  logic           clk,
    input  logic           rst,
    vga_scan_out_if.master bus
);

    logic [1:0]  div;
    logic        pix_tick;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic        h_end;
    logic        v_end;
    logic        visible;
    logic        hs_raw;
    logic        vs_raw;
    logic [16:0] rom_addr;
    logic        draw_d;
    logic        vis_d;
    logic        hs_d;
    logic        vs_d;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic        hsync;
    logic        vsync;

    // Halve a colour channel when dimming is requested.
    function automatic logic [3:0] shade(input logic [3:0] ch, input logic half);
        return half ? {1'b0, ch[3:1]} : ch;
    endfunction

    // Free-running divide-by-4 giving one pixel tick every fourth clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div <= 2'd0;
        end else begin
            div <= div + 2'd1;
        end
    end

    assign pix_tick = (div == 2'd3);
    assign h_end    = (h_cnt == H_MAX);
    assign v_end    = (v_cnt == V_MAX);

    // Raster position: advance one pixel per tick, wrap line and frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= 10'd0;
            v_cnt <= 10'd0;
        end else if (pix_tick) begin
            if (h_end) begin
                h_cnt <= 10'd0;
                v_cnt <= v_end ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    assign visible = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE);
    assign hs_raw  = !((h_cnt >= H_SYNC_START) && (h_cnt <= H_SYNC_END));
    assign vs_raw  = !((v_cnt >= V_SYNC_START) && (v_cnt <= V_SYNC_END));

    // Stage 1: latch ROM address and per-pixel flags for the current position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_addr <= 17'd0;
            draw_d   <= 1'b0;
            vis_d    <= 1'b0;
            hs_d     <= 1'b1;
            vs_d     <= 1'b1;
        end else if (pix_tick) begin
            rom_addr <= bus.pixel_addr;
            draw_d   <= visible && bus.notBlank;
            vis_d    <= visible;
            hs_d     <= hs_raw;
            vs_d     <= vs_raw;
        end
    end

    // Stage 2: colour from the ROM word (blanked outside drawn pixels) and syncs.
    // The ROM word has had a full pixel period (4 clk) to settle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            red   <= 4'd0;
            green <= 4'd0;
            blue  <= 4'd0;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else if (pix_tick) begin
            if (draw_d && vis_d) begin
                red   <= shade(bus.rom_data[11:8], bus.dim);
                green <= shade(bus.rom_data[7:4], bus.dim);
                blue  <= shade(bus.rom_data[3:0], bus.dim);
            end else begin
                red   <= 4'd0;
                green <= 4'd0;
                blue  <= 4'd0;
            end
            hsync <= hs_d;
            vsync <= vs_d;
        end
    end

    assign bus.h_cnt       = h_cnt;
    assign bus.v_cnt       = v_cnt;
    assign bus.rom_addr    = rom_addr;
    assign bus.vgaRed      = red;
    assign bus.vgaGreen    = green;
    assign bus.vgaBlue     = blue;
    assign bus.hsync       = hsync;
    assign bus.vsync       = vsync;
    // High only in the clk whose tick wraps the raster back to (0,0).
    assign bus.frame_start = pix_tick && h_end && v_end;

endmodule

// File: tb/tb_vga_scan_out.sv
// Bench for vga_scan_out. A reduced raster instance (28x10) carries the
// scoreboard checks over whole frames; a default-timing instance checks one
// full 800-pixel line including the 96-pixel hsync window.
module tb_vga_scan_out;

    localparam int HV  = 16;
    localparam int HSS = 18;
    localparam int HSE = 21;
    localparam int HM  = 27;
    localparam int VV  = 6;
    localparam int VSS = 7;
    localparam int VSE = 8;
    localparam int VM  = 9;
    localparam int FRAME_CLK = (HM + 1) * (VM + 1) * 4;

    typedef struct packed {
        logic        draw;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } entry_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rel_cyc = 0;
    logic [1:0] m_div;
    int mh = 0;
    int mv = 0;
    logic [11:0] exp_rgb;
    logic        exp_hs;
    logic        exp_vs;
    logic [16:0] exp_rom;
    entry_t sb[$];
    int fs_q[$];
    logic [11:0] rom_p1;
    logic [11:0] rom_p2;

    vga_scan_out_if bus();
    vga_scan_out_if bus_f();

    vga_scan_out #(
        .H_VISIBLE(10'd16), .H_SYNC_START(10'd18), .H_SYNC_END(10'd21), .H_MAX(10'd27),
        .V_VISIBLE(10'd6),  .V_SYNC_START(10'd7),  .V_SYNC_END(10'd8),  .V_MAX(10'd9)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    vga_scan_out dut_full (
        .clk(clk),
        .rst(rst),
        .bus(bus_f)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) m_div <= 2'd0;
        else     m_div <= m_div + 2'd1;
    end

    // Pixel ROM with 3 clk latency; contents are the low 12 address bits.
    always @(posedge clk) begin
        rom_p1       <= bus.rom_addr[11:0];
        rom_p2       <= rom_p1;
        bus.rom_data <= rom_p2;
    end

    always @(negedge clk) begin
        if (bus.frame_start === 1'b1) fs_q.push_back(cyc);
    end

    function automatic logic m_vis(input int h, input int v);
        return (h < HV) && (v < VV);
    endfunction

    function automatic logic m_hs(input int h);
        return !((h >= HSS) && (h <= HSE));
    endfunction

    function automatic logic m_vs(input int v);
        return !((v >= VSS) && (v <= VSE));
    endfunction

    function automatic logic [11:0] m_dim(input logic [11:0] c);
        return {1'b0, c[11:9], 1'b0, c[7:5], 1'b0, c[3:1]};
    endfunction

    task automatic apply_reset(input int hold);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.h_cnt !== 10'd0 || bus.v_cnt !== 10'd0) begin
            errors++;
            $display("FAIL reset_counters: got h=%0d v=%0d, expected h=0 v=0", bus.h_cnt, bus.v_cnt);
        end
        checks++;
        if (bus.rom_addr !== 17'd0) begin
            errors++;
            $display("FAIL reset_rom_addr: got %h, expected 00000", bus.rom_addr);
        end
        checks++;
        if ({bus.vgaRed, bus.vgaGreen, bus.vgaBlue} !== 12'h000 || bus.hsync !== 1'b1 ||
            bus.vsync !== 1'b1 || bus.frame_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_pins: got rgb=%h hs=%b vs=%b fs=%b, expected rgb=000 hs=1 vs=1 fs=0",
                     {bus.vgaRed, bus.vgaGreen, bus.vgaBlue}, bus.hsync, bus.vsync, bus.frame_start);
        end
        repeat (hold) @(posedge clk);
        #1;
        checks++;
        if (bus.h_cnt !== 10'd0 || bus_f.h_cnt !== 10'd0) begin
            errors++;
            $display("FAIL reset_hold: got h=%0d h_full=%0d, expected 0 0", bus.h_cnt, bus_f.h_cnt);
        end
        rst = 1'b0;
        rel_cyc = cyc;
        mh = 0;
        mv = 0;
        sb.delete();
        sb.push_back('{draw: 1'b0, rgb: 12'h000, hs: 1'b1, vs: 1'b1});
        exp_rgb = 12'h000;
        exp_hs = 1'b1;
        exp_vs = 1'b1;
        exp_rom = 17'd0;
    endtask

    // Runs the reduced instance up to and through its next pixel tick,
    // checking counters, ROM address, pins and frame_start on every clk.
    task automatic do_tick(input logic [16:0] addr, input logic nb, input logic dm,
                           input bit glitch, output int waited);
        entry_t s2;
        entry_t e;
        logic exp_fs;
        waited = 0;
        if (glitch) begin
            bus.pixel_addr = ~addr;
            bus.notBlank = ~nb;
            bus.dim = ~dm;
        end
        for (int k = 0; k < 8; k++) begin
            exp_fs = (m_div == 2'd3) && (mh == HM) && (mv == VM);
            checks++;
            if (bus.h_cnt !== 10'(mh) || bus.v_cnt !== 10'(mv)) begin
                errors++;
                $display("FAIL counters: got h=%0d v=%0d, expected h=%0d v=%0d", bus.h_cnt, bus.v_cnt, mh, mv);
            end
            checks++;
            if (bus.rom_addr !== exp_rom) begin
                errors++;
                $display("FAIL rom_addr: got %h, expected %h", bus.rom_addr, exp_rom);
            end
            checks++;
            if ({bus.vgaRed, bus.vgaGreen, bus.vgaBlue} !== exp_rgb || bus.hsync !== exp_hs ||
                bus.vsync !== exp_vs) begin
                errors++;
                $display("FAIL pins at h=%0d v=%0d: got rgb=%h hs=%b vs=%b, expected rgb=%h hs=%b vs=%b",
                         mh, mv, {bus.vgaRed, bus.vgaGreen, bus.vgaBlue}, bus.hsync, bus.vsync,
                         exp_rgb, exp_hs, exp_vs);
            end
            checks++;
            if (bus.frame_start !== exp_fs) begin
                errors++;
                $display("FAIL frame_start at h=%0d v=%0d: got %b, expected %b", mh, mv, bus.frame_start, exp_fs);
            end
            if (m_div == 2'd3) break;
            @(posedge clk);
            #1;
            waited++;
        end
        bus.pixel_addr = addr;
        bus.notBlank = nb;
        bus.dim = dm;
        s2 = '0;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: got empty queue, expected one pending entry");
        end else begin
            s2 = sb.pop_front();
        end
        exp_rgb = s2.draw ? (dm ? m_dim(s2.rgb) : s2.rgb) : 12'h000;
        exp_hs = s2.hs;
        exp_vs = s2.vs;
        e.draw = m_vis(mh, mv) && nb;
        e.rgb = addr[11:0];
        e.hs = m_hs(mh);
        e.vs = m_vs(mv);
        sb.push_back(e);
        exp_rom = addr;
        @(posedge clk);
        #1;
        if (mh == HM) begin
            mh = 0;
            mv = (mv == VM) ? 0 : mv + 1;
        end else begin
            mh++;
        end
    endtask

    task automatic test_reset();
        apply_reset(2);
    endtask

    task automatic test_first_ticks();
        int waited;
        do_tick(17'h00F84, 1'b1, 1'b0, 1'b0, waited);
        checks++;
        if (waited != 3) begin
            errors++;
            $display("FAIL first_tick_edge: got edge %0d, expected edge 4", waited + 1);
        end
        checks++;
        if ({bus.vgaRed, bus.vgaGreen, bus.vgaBlue} !== 12'h000 || bus.hsync !== 1'b1 || bus.vsync !== 1'b1) begin
            errors++;
            $display("FAIL flush_tick1: got rgb=%h hs=%b vs=%b, expected 000 1 1",
                     {bus.vgaRed, bus.vgaGreen, bus.vgaBlue}, bus.hsync, bus.vsync);
        end
        do_tick(17'h00F84, 1'b1, 1'b0, 1'b0, waited);
        checks++;
        if ({bus.vgaRed, bus.vgaGreen, bus.vgaBlue} !== 12'hF84 || (cyc - rel_cyc) != 8) begin
            errors++;
            $display("FAIL colour_origin: got rgb=%h after %0d clk, expected F84 after 8 clk",
                     {bus.vgaRed, bus.vgaGreen, bus.vgaBlue}, cyc - rel_cyc);
        end
        do_tick(17'h00F84, 1'b1, 1'b1, 1'b0, waited);
        checks++;
        if ({bus.vgaRed, bus.vgaGreen, bus.vgaBlue} !== 12'h742) begin
            errors++;
            $display("FAIL colour_dim: got rgb=%h, expected 742", {bus.vgaRed, bus.vgaGreen, bus.vgaBlue});
        end
        do_tick(17'h00000, 1'b0, 1'b0, 1'b0, waited);
    endtask

    task automatic test_glitch();
        int waited;
        for (int i = 0; i < 4; i++) do_tick(17'h12C00, 1'b1, 1'b0, 1'b1, waited);
        checks++;
        if (bus.rom_addr !== 17'h12C00) begin
            errors++;
            $display("FAIL glitch_rom_addr: got %h, expected 12c00", bus.rom_addr);
        end
        do_tick(17'h12C00, 1'b1, 1'b0, 1'b1, waited);
    endtask

    task automatic test_visible_frame();
        int waited;
        int lit = 0;
        for (int k = 1; k <= 282; k++) begin
            do_tick(17'h00FFF, 1'b1, 1'b0, 1'b0, waited);
            if (k >= 3 && {bus.vgaRed, bus.vgaGreen, bus.vgaBlue} !== 12'h000) lit++;
        end
        checks++;
        if (lit != HV * VV) begin
            errors++;
            $display("FAIL visible_area: got %0d lit pixels per frame, expected %0d", lit, HV * VV);
        end
    endtask

    task automatic test_random_frames();
        int waited;
        fs_q.delete();
        for (int k = 0; k < 570; k++)
            do_tick(17'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), waited);
        checks++;
        if (fs_q.size() < 2) begin
            errors++;
            $display("FAIL frame_pulses: got %0d pulses, expected at least 2", fs_q.size());
        end else if (fs_q[1] - fs_q[0] != FRAME_CLK) begin
            errors++;
            $display("FAIL frame_period: got %0d clk, expected %0d", fs_q[1] - fs_q[0], FRAME_CLK);
        end
    endtask

    task automatic test_reset_midline();
        int waited;
        int n = 0;
        while (!(mh == 20 && mv == 5) && n < 400) begin
            do_tick(17'($urandom), 1'b1, 1'b0, 1'b0, waited);
            n++;
        end
        checks++;
        if (!(mh == 20 && mv == 5)) begin
            errors++;
            $display("FAIL midline_reach: got h=%0d v=%0d, expected h=20 v=5", mh, mv);
        end
        @(posedge clk);
        #1;
        apply_reset(2);
        fs_q.delete();
        do_tick(17'($urandom), 1'b1, 1'b0, 1'b0, waited);
        checks++;
        if (waited != 3) begin
            errors++;
            $display("FAIL midline_first_tick: got edge %0d, expected edge 4", waited + 1);
        end
        for (int k = 1; k < 281; k++)
            do_tick(17'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, waited);
        checks++;
        if (fs_q.size() != 1 || fs_q[0] != rel_cyc + FRAME_CLK - 1) begin
            errors++;
            $display("FAIL frame_after_reset: got %0d pulses first at clk %0d, expected 1 pulse at clk %0d",
                     fs_q.size(), (fs_q.size() > 0) ? fs_q[0] - rel_cyc : -1, FRAME_CLK - 1);
        end
    endtask

    task automatic test_full_line();
        int fh = 0;
        int fv = 0;
        int low = 0;
        int first_low = -1;
        int p;
        logic exp_h;
        apply_reset(2);
        for (int k = 1; k <= 802; k++) begin
            for (int n = 0; n < 8 && m_div != 2'd3; n++) begin
                @(posedge clk);
                #1;
            end
            checks++;
            if (bus_f.h_cnt !== 10'(fh) || bus_f.v_cnt !== 10'(fv)) begin
                errors++;
                $display("FAIL full_counters: got h=%0d v=%0d, expected h=%0d v=%0d", bus_f.h_cnt, bus_f.v_cnt, fh, fv);
            end
            @(posedge clk);
            #1;
            if (fh == 799) begin
                fh = 0;
                fv++;
            end else begin
                fh++;
            end
            p = (k - 2) % 800;
            exp_h = (k < 2) ? 1'b1 : !((p >= 656) && (p <= 751));
            checks++;
            if (bus_f.hsync !== exp_h || bus_f.vsync !== 1'b1 ||
                {bus_f.vgaRed, bus_f.vgaGreen, bus_f.vgaBlue} !== 12'h000) begin
                errors++;
                $display("FAIL full_sync tick %0d: got hs=%b vs=%b rgb=%h, expected hs=%b vs=1 rgb=000",
                         k, bus_f.hsync, bus_f.vsync, {bus_f.vgaRed, bus_f.vgaGreen, bus_f.vgaBlue}, exp_h);
            end
            if (bus_f.hsync === 1'b0) begin
                low++;
                if (first_low < 0) first_low = k;
            end
        end
        checks++;
        if (low != 96 || first_low != 658) begin
            errors++;
            $display("FAIL full_hsync_window: got %0d low ticks from tick %0d, expected 96 from tick 658", low, first_low);
        end
    endtask

    initial begin
        bus.pixel_addr = 17'd0;
        bus.notBlank = 1'b0;
        bus.dim = 1'b0;
        bus_f.pixel_addr = 17'd0;
        bus_f.notBlank = 1'b0;
        bus_f.dim = 1'b0;
        bus_f.rom_data = 12'h000;
        #2;
        test_reset();
        test_first_ticks();
        test_glitch();
        test_visible_frame();
        test_random_frames();
        test_reset_midline();
        test_full_line();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
